// File: rtl/neural_layer_ctrl_if.sv
// Bus bundle for neural_layer_ctrl: host-side command/result signals plus the
// command/completion pair toward the neuron datapath.
// Handshake: n_start is a one-cycle command for row n_row; the datapath answers
// later with a one-cycle n_done carrying n_result. There is no backpressure on
// either side, and a strobe counts only in the state that expects it.
interface neural_layer_ctrl_if #(
  parameter int IN_SIZE  = 1,
  parameter int OUT_SIZE = 1,
  parameter int ROW_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
);
  logic                    start;
  logic                    abort;
  logic                    activation;
  logic [32*IN_SIZE-1:0]   in;
  logic                    busy;
  logic                    done;
  logic [32*OUT_SIZE-1:0]  result;
  logic                    n_start;
  logic [ROW_W-1:0]        n_row;
  logic [32*IN_SIZE-1:0]   n_in;
  logic                    n_activation;
  logic                    n_done;
  logic [31:0]             n_result;
  logic [1:0]              fsm_state;  // debug view of the controller state

  modport master (
    input  start, abort, activation, in, n_done, n_result,
    output busy, done, result, n_start, n_row, n_in, n_activation, fsm_state
  );

  modport slave (
    output start, abort, activation, in, n_done, n_result,
    input  busy, done, result, n_start, n_row, n_in, n_activation, fsm_state
  );
endinterface

// File: rtl/neural_layer_ctrl.sv
// Sequences one layer evaluation: issues one datapath command per neuron row,
// collects each activated output into its result slot, then pulses done.
// Data words pass through untouched; all outputs come straight from registers.
module neural_layer_ctrl #(
  parameter int IN_SIZE  = 1,
  parameter int OUT_SIZE = 1,
  localparam int ROW_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input logic              clk,
  input logic              rst,
  neural_layer_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_SIZE - 1);

  assign bus.fsm_state = state;

  // Controller FSM with registered outputs; abort and reset both return to IDLE,
  // but only reset clears the result vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.n_start      <= 1'b0;
      bus.n_row        <= '0;
      bus.n_activation <= 1'b0;
      bus.n_in         <= '0;
      bus.result       <= '0;
    end else begin
      // Both strobes are single-cycle unless a branch re-asserts them.
      bus.n_start <= 1'b0;
      bus.done    <= 1'b0;
      case (state)
        IDLE: begin
          // abort outranks start even though abort alone does nothing here.
          if (bus.start && !bus.abort) begin
            bus.n_in         <= bus.in;
            bus.n_activation <= bus.activation;
            bus.n_row        <= '0;
            bus.n_start      <= 1'b1;
            bus.busy         <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // abort beats a coinciding n_done, so that row's slot is not written.
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (bus.n_done) begin
            for (int k = 0; k < OUT_SIZE; k++) begin
              if (bus.n_row == ROW_W'(k)) begin
                bus.result[32*k +: 32] <= bus.n_result;
              end
            end
            if (bus.n_row == LAST_ROW) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              bus.n_row   <= bus.n_row + ROW_W'(1);
              bus.n_start <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neural_layer_ctrl.sv
// Directed bench for neural_layer_ctrl: a 3-row instance exercised through a
// scoreboard of expected n_start/done events, plus a 1-row instance.
module tb_neural_layer_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  neural_layer_ctrl_if #(.IN_SIZE(2), .OUT_SIZE(3)) bus3();
  neural_layer_ctrl_if #(.IN_SIZE(1), .OUT_SIZE(1)) bus1();

  neural_layer_ctrl #(.IN_SIZE(2), .OUT_SIZE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  neural_layer_ctrl #(.IN_SIZE(1), .OUT_SIZE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0]  exp_start_q[$];  // {cycle[23:0], row[7:0]}
  logic [127:0] exp_done_q[$];   // {cycle[31:0], result[95:0]}
  logic [63:0]  exp_in;
  logic         exp_act;
  logic [31:0]  es;
  logic [127:0] ed;

  // ---------------- datapath responder ----------------
  int unsigned  lat[3];
  logic [31:0]  resp[3];
  int unsigned  due[3];
  logic         pend[3];
  logic         auto_done;
  logic         man_done;
  logic [31:0]  auto_res;
  logic [31:0]  man_res;

  assign bus3.n_done   = auto_done | man_done;
  assign bus3.n_result = man_done ? man_res : auto_res;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Returns at the negedge just before edge t, so anything driven now is sampled at t.
  task automatic at_edge(int unsigned t);
    while (cyc + 1 < t) @(negedge clk);
  endtask

  task automatic push_start(int unsigned c, int r);
    exp_start_q.push_back({c[23:0], 8'(r)});
  endtask

  task automatic push_done(int unsigned c, logic [95:0] res);
    exp_done_q.push_back({c, res});
  endtask

  // Responder: answers each n_start after lat[row] cycles (lat 0 = never).
  always @(negedge clk) begin
    auto_done = 1'b0;
    if (rst) begin
      for (int r = 0; r < 3; r++) pend[r] = 1'b0;
    end else begin
      if (bus3.n_start && lat[bus3.n_row] != 0) begin
        pend[bus3.n_row] = 1'b1;
        due[bus3.n_row]  = cyc + 1 + lat[bus3.n_row];
      end
      for (int r = 0; r < 3; r++) begin
        if (pend[r] && due[r] == cyc + 1) begin
          auto_done = 1'b1;
          auto_res  = resp[r];
          pend[r]   = 1'b0;
        end
      end
    end
  end

  // Monitor: every n_start / done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && bus3.n_start) begin
      if (exp_start_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL n_start_unexpected: row %0d at cycle %0d, none expected", bus3.n_row, cyc + 1);
      end else begin
        es = exp_start_q.pop_front();
        check("n_start_cycle_row", {96'd0, 24'(cyc + 1), 8'(bus3.n_row)}, {96'd0, es});
        check("n_activation", {127'd0, bus3.n_activation}, {127'd0, exp_act});
        check("n_in", {64'd0, bus3.n_in}, {64'd0, exp_in});
      end
    end
    if (!rst && bus3.done) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: done at cycle %0d, none expected", cyc + 1);
      end else begin
        ed = exp_done_q.pop_front();
        check("done_cycle_result", {32'(cyc + 1), bus3.result}, ed);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned t;
    rst = 1'b1;
    bus3.start = 1'b0; bus3.abort = 1'b0; bus3.activation = 1'b0; bus3.in = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.activation = 1'b0; bus1.in = '0;
    bus1.n_done = 1'b0; bus1.n_result = '0;
    man_done = 1'b0; man_res = '0; auto_done = 1'b0; auto_res = '0;
    for (int r = 0; r < 3; r++) begin lat[r] = 0; resp[r] = '0; pend[r] = 1'b0; due[r] = 0; end
    exp_in = '0; exp_act = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", {127'd0, bus3.busy}, 128'd0);
    check("rst_done", {127'd0, bus3.done}, 128'd0);
    check("rst_n_start", {127'd0, bus3.n_start}, 128'd0);
    check("rst_n_row", {126'd0, bus3.n_row}, 128'd0);
    check("rst_n_in", {64'd0, bus3.n_in}, 128'd0);
    check("rst_result", {32'd0, bus3.result}, 128'd0);
    check("rst_state", {126'd0, bus3.fsm_state}, 128'd0);
    check("rst1_busy", {127'd0, bus1.busy}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic run, L=1 for every row
    lat = '{1, 1, 1};
    resp = '{32'h3F000000, 32'h3F400000, 32'h3F800000};
    exp_in = {32'h40000000, 32'h3F800000}; exp_act = 1'b1;
    t = cyc + 1;
    bus3.in = exp_in; bus3.activation = 1'b1; bus3.start = 1'b1;
    push_start(t + 1, 0); push_start(t + 3, 1); push_start(t + 5, 2);
    push_done(t + 7, {32'h3F800000, 32'h3F400000, 32'h3F000000});
    at_edge(t + 1); bus3.start = 1'b0;
    at_edge(t + 4);
    check("busy_mid_run", {127'd0, bus3.busy}, 128'd1);
    at_edge(t + 9);

    // Variable latency: row 1 takes 4 cycles
    lat = '{1, 4, 1};
    resp = '{32'h11111111, 32'h22222222, 32'h33333333};
    t = cyc + 1;
    bus3.start = 1'b1;
    push_start(t + 1, 0); push_start(t + 3, 1); push_start(t + 8, 2);
    push_done(t + 10, {32'h33333333, 32'h22222222, 32'h11111111});
    at_edge(t + 1); bus3.start = 1'b0;
    at_edge(t + 12);

    // Ignored inputs: n_done in ISSUE, start while busy, start in DONE, then restart
    lat = '{2, 2, 2};
    resp = '{32'hA0000001, 32'hA0000002, 32'hA0000003};
    exp_in = {32'hC0000000, 32'h01234567}; exp_act = 1'b0;
    t = cyc + 1;
    bus3.in = exp_in; bus3.activation = 1'b0; bus3.start = 1'b1;
    push_start(t + 1, 0); push_start(t + 4, 1); push_start(t + 7, 2);
    push_done(t + 10, {32'hA0000003, 32'hA0000002, 32'hA0000001});
    at_edge(t + 1); bus3.start = 1'b0; man_done = 1'b1; man_res = 32'hBAD0BAD0;
    at_edge(t + 2); man_done = 1'b0;
    at_edge(t + 5); bus3.start = 1'b1; bus3.in = '1; bus3.activation = 1'b1;
    at_edge(t + 6); bus3.start = 1'b0;
    at_edge(t + 10);
    lat = '{1, 1, 1};
    resp = '{32'h0C0C0C01, 32'h0C0C0C02, 32'h0C0C0C03};
    exp_in = {32'h55555555, 32'h66666666}; exp_act = 1'b1;
    bus3.in = exp_in; bus3.activation = 1'b1; bus3.start = 1'b1;
    push_start(t + 12, 0); push_start(t + 14, 1); push_start(t + 16, 2);
    push_done(t + 18, {32'h0C0C0C03, 32'h0C0C0C02, 32'h0C0C0C01});
    at_edge(t + 12); bus3.start = 1'b0;
    at_edge(t + 20);

    // Abort in WAIT of row 1, coinciding with n_done
    lat = '{1, 6, 1};
    resp = '{32'hD0000000, 32'hE0000000, 32'hF0000000};
    exp_in = {32'h00000001, 32'h00000002}; exp_act = 1'b0;
    t = cyc + 1;
    bus3.in = exp_in; bus3.activation = 1'b0; bus3.start = 1'b1;
    push_start(t + 1, 0); push_start(t + 3, 1);
    at_edge(t + 1); bus3.start = 1'b0;
    at_edge(t + 4); bus3.abort = 1'b1; man_done = 1'b1; man_res = 32'hDEADBEEF;
    at_edge(t + 5); bus3.abort = 1'b0; man_done = 1'b0;
    check("abort_busy", {127'd0, bus3.busy}, 128'd0);
    check("abort_state", {126'd0, bus3.fsm_state}, 128'd0);
    check("abort_result", {32'd0, bus3.result}, {32'd0, 32'h0C0C0C03, 32'h0C0C0C02, 32'hD0000000});
    at_edge(t + 12);
    check("idle_n_done_ignored", {32'd0, bus3.result}, {32'd0, 32'h0C0C0C03, 32'h0C0C0C02, 32'hD0000000});
    bus3.abort = 1'b1; bus3.start = 1'b1;
    at_edge(t + 13); bus3.abort = 1'b0; bus3.start = 1'b0;
    check("abort_beats_start", {127'd0, bus3.busy}, 128'd0);
    at_edge(t + 15);

    // Reset in WAIT of row 2
    lat = '{1, 1, 0};
    resp = '{32'h01010101, 32'h02020202, 32'h03030303};
    exp_in = {32'h00000007, 32'h00000008}; exp_act = 1'b1;
    t = cyc + 1;
    bus3.in = exp_in; bus3.activation = 1'b1; bus3.start = 1'b1;
    push_start(t + 1, 0); push_start(t + 3, 1); push_start(t + 5, 2);
    at_edge(t + 1); bus3.start = 1'b0;
    at_edge(t + 6); rst = 1'b1;
    at_edge(t + 7); rst = 1'b0;
    check("mid_rst_busy", {127'd0, bus3.busy}, 128'd0);
    check("mid_rst_result", {32'd0, bus3.result}, 128'd0);
    check("mid_rst_n_row", {126'd0, bus3.n_row}, 128'd0);
    check("mid_rst_n_in", {64'd0, bus3.n_in}, 128'd0);
    check("mid_rst_n_act", {127'd0, bus3.n_activation}, 128'd0);
    at_edge(t + 8); man_done = 1'b1; man_res = 32'hFFFFFFFF;
    at_edge(t + 9); man_done = 1'b0;
    at_edge(t + 10);
    check("post_rst_n_done_ignored", {32'd0, bus3.result}, 128'd0);

    // Single-row instance, L=1
    t = cyc + 1;
    bus1.in = 32'h3F800000; bus1.activation = 1'b1; bus1.start = 1'b1;
    at_edge(t + 1); bus1.start = 1'b0;
    check("one_n_start", {127'd0, bus1.n_start}, 128'd1);
    check("one_n_row", {127'd0, bus1.n_row}, 128'd0);
    check("one_n_in", {96'd0, bus1.n_in}, {96'd0, 32'h3F800000});
    at_edge(t + 2); bus1.n_done = 1'b1; bus1.n_result = 32'h12345678;
    check("one_n_start_single", {127'd0, bus1.n_start}, 128'd0);
    at_edge(t + 3); bus1.n_done = 1'b0;
    check("one_done", {127'd0, bus1.done}, 128'd1);
    check("one_result", {96'd0, bus1.result}, {96'd0, 32'h12345678});
    at_edge(t + 4);
    check("one_done_single", {127'd0, bus1.done}, 128'd0);
    check("one_busy_clear", {127'd0, bus1.busy}, 128'd0);

    at_edge(cyc + 3);
    check("start_q_drained", 128'(exp_start_q.size()), 128'd0);
    check("done_q_drained", 128'(exp_done_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
